// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised VGA-style timing generator.
// Produces hsync/vsync, pixel coordinates, a visible-area flag, line/frame
// strobes and a wrapping completed-frame counter. Counters advance only on
// clk edges with pix_ce=1, so it can run from the system clock.
// Optional feature macro: VIDEO_TIMING_LOOKAHEAD_EN -- when defined, xpos/ypos
// show the next pixel (one ahead of hsync/vsync/active) for registered renderers.
module video_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 11,
  parameter int   FCW      = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pix_ce,
  output logic           hsync,
  output logic           vsync,
  output logic [CW-1:0]  xpos,
  output logic [CW-1:0]  ypos,
  output logic           active,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Position on the sync/active timeline and the position it moves to next.
  logic [CW-1:0] cur_x, cur_y;
  logic [CW-1:0] nxt_x, nxt_y;
  logic          h_wrap, v_wrap;

  // Next-pixel arithmetic; sync/active are decoded from this so the
  // registered levels line up with the registered coordinates.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    h_wrap = (cur_x == H_LAST);
    v_wrap = (cur_y == V_LAST);
    nxt_x  = h_wrap ? '0 : cur_x + CW'(1);
    nxt_y  = cur_y;
    if (h_wrap) nxt_y = v_wrap ? '0 : cur_y + CW'(1);
  end

  // Coordinate counters, decoded levels, strobes and frame counter.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so all of them
    // update together from the values sampled at the same edge.
    if (reset) begin
      cur_x       <= '0;
      cur_y       <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      active      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_ce) begin
        cur_x       <= nxt_x;
        cur_y       <= nxt_y;
        hsync       <= (nxt_x >= HS_FIRST && nxt_x <= HS_LAST) ? HS_POL : ~HS_POL;
        vsync       <= (nxt_y >= VS_FIRST && nxt_y <= VS_LAST) ? VS_POL : ~VS_POL;
        active      <= (nxt_x < H_VIS) && (nxt_y < V_VIS);
        line_start  <= h_wrap;
        frame_start <= h_wrap & v_wrap;
        if (h_wrap && v_wrap) frame_count <= frame_count + FCW'(1);
      end
    end
  end

`ifdef VIDEO_TIMING_LOOKAHEAD_EN
  // Lookahead coordinates always hold the pixel after cur_x/cur_y.
  logic [CW-1:0] la_x, la_y;
  logic [CW-1:0] la_nx, la_ny;

  // Pixel after nxt_x/nxt_y: what the lookahead registers hold after an advance.
  always_comb begin
    la_nx = (nxt_x == H_LAST) ? '0 : nxt_x + CW'(1);
    la_ny = nxt_y;
    if (nxt_x == H_LAST) la_ny = (nxt_y == V_LAST) ? '0 : nxt_y + CW'(1);
  end

  // Lookahead coordinate registers; out of reset they point at pixel (1,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      la_x <= CW'(1);
      la_y <= '0;
    end else if (pix_ce) begin
      la_x <= la_nx;
      la_y <= la_ny;
    end
  end

  assign xpos = la_x;
  assign ypos = la_y;
`else
  assign xpos = cur_x;
  assign ypos = cur_y;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: a small 7x6 mode (active-high
// syncs, 2-bit frame counter) and the default 800x525 mode side by side.
module tb_video_timing_gen;

`ifdef VIDEO_TIMING_LOOKAHEAD_EN
  localparam bit LOOKAHEAD = 1'b1;
`else
  localparam bit LOOKAHEAD = 1'b0;
`endif

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic pix_ce = 1'b0;

  logic       s_hsync, s_vsync, s_active, s_line_start, s_frame_start;
  logic [3:0] s_xpos, s_ypos;
  logic [1:0] s_frame_count;

  logic        d_hsync, d_vsync, d_active, d_line_start, d_frame_start;
  logic [10:0] d_xpos, d_ypos;
  logic [15:0] d_frame_count;

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .FCW(2)
  ) u_small (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .hsync(s_hsync), .vsync(s_vsync), .xpos(s_xpos), .ypos(s_ypos),
    .active(s_active), .line_start(s_line_start), .frame_start(s_frame_start),
    .frame_count(s_frame_count)
  );

  video_timing_gen u_dflt (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .hsync(d_hsync), .vsync(d_vsync), .xpos(d_xpos), .ypos(d_ypos),
    .active(d_active), .line_start(d_line_start), .frame_start(d_frame_start),
    .frame_count(d_frame_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int ncyc  = 0;

  // Reference positions on the sync timeline.
  int         sx, sy, dx, dy;
  logic [1:0] sfc;
  logic       s_ls_e, s_fs_e, d_ls_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, ncyc);
    end
  endtask

  task automatic model_reset();
    sx = 0; sy = 0; dx = 0; dy = 0; sfc = 2'd0;
    s_ls_e = 1'b0; s_fs_e = 1'b0; d_ls_e = 1'b0;
  endtask

  task automatic check_reset_values(input string ph);
    check({ph, "_s_x"},   32'(s_xpos),        LOOKAHEAD ? 32'd1 : 32'd0);
    check({ph, "_s_y"},   32'(s_ypos),        32'd0);
    check({ph, "_s_hs"},  32'(s_hsync),       32'd0);
    check({ph, "_s_vs"},  32'(s_vsync),       32'd0);
    check({ph, "_s_act"}, 32'(s_active),      32'd1);
    check({ph, "_s_ls"},  32'(s_line_start),  32'd0);
    check({ph, "_s_fs"},  32'(s_frame_start), 32'd0);
    check({ph, "_s_fc"},  32'(s_frame_count), 32'd0);
    check({ph, "_d_x"},   32'(d_xpos),        LOOKAHEAD ? 32'd1 : 32'd0);
    check({ph, "_d_hs"},  32'(d_hsync),       32'd1);
    check({ph, "_d_vs"},  32'(d_vsync),       32'd1);
    check({ph, "_d_fc"},  32'(d_frame_count), 32'd0);
  endtask

  // One clock: drive pix_ce at the falling edge, sample 1 ns after the rising
  // edge, advance the reference and compare every output. Ends on a falling edge.
  task automatic tick(input logic ce);
    int ex, ey, fx, fy;
    pix_ce = ce;
    @(posedge clk);
    #1;
    ncyc++;
    if (ce) begin
      s_ls_e = (sx == 6);
      s_fs_e = s_ls_e && (sy == 5);
      if (s_ls_e) begin sx = 0; sy = (sy == 5) ? 0 : sy + 1; end
      else sx++;
      if (s_fs_e) sfc = sfc + 2'd1;
      d_ls_e = (dx == 799);
      if (d_ls_e) begin dx = 0; dy = (dy == 524) ? 0 : dy + 1; end
      else dx++;
    end else begin
      s_ls_e = 1'b0; s_fs_e = 1'b0; d_ls_e = 1'b0;
    end
    ex = sx; ey = sy; fx = dx; fy = dy;
    if (LOOKAHEAD) begin
      ex = (sx == 6) ? 0 : sx + 1;
      ey = (sx == 6) ? ((sy == 5) ? 0 : sy + 1) : sy;
      fx = (dx == 799) ? 0 : dx + 1;
      fy = (dx == 799) ? ((dy == 524) ? 0 : dy + 1) : dy;
    end
    check("s_x",   32'(s_xpos),        ex);
    check("s_y",   32'(s_ypos),        ey);
    check("s_hs",  32'(s_hsync),       32'(sx == 5));
    check("s_vs",  32'(s_vsync),       32'(sy == 4));
    check("s_act", 32'(s_active),      32'(sx < 4 && sy < 3));
    check("s_ls",  32'(s_line_start),  32'(s_ls_e));
    check("s_fs",  32'(s_frame_start), 32'(s_fs_e));
    check("s_fc",  32'(s_frame_count), 32'(sfc));
    check("d_x",   32'(d_xpos),        fx);
    check("d_y",   32'(d_ypos),        fy);
    check("d_hs",  32'(d_hsync),       32'(!(dx >= 656 && dx <= 751)));
    check("d_vs",  32'(d_vsync),       32'(!(dy >= 490 && dy <= 491)));
    check("d_act", 32'(d_active),      32'(dx < 640 && dy < 480));
    check("d_ls",  32'(d_line_start),  32'(d_ls_e));
    @(negedge clk);
  endtask

  initial begin
    int first_fs, fs_a, fs_b, fc_at_fs;

    // Reset values while reset is held.
    model_reset();
    #12;
    check_reset_values("por");
    @(negedge clk);
    reset = 1'b0;

    // Continuous pix_ce: small mode frame is 7x6 = 42 clks.
    first_fs = 0;
    for (int i = 0; i < 1700; i++) begin
      tick(1'b1);
      if (s_frame_start && first_fs == 0) first_fs = ncyc;
      if (ncyc == 210) check("fc_wrap_after_5_frames", 32'(s_frame_count), 32'd1);
    end
    check("first_frame_start_clks", first_fs, 32'd42);

    // pix_ce toggling: frame period doubles to 84 clks.
    fs_a = 0; fs_b = 0;
    for (int i = 0; i < 300; i++) begin
      tick((i % 2) == 0);
      if (s_frame_start) begin
        if (fs_a == 0) fs_a = ncyc;
        else if (fs_b == 0) fs_b = ncyc;
      end
    end
    check("fs_period_half_rate", fs_b - fs_a, 32'd84);

    // Asynchronous reset between edges takes effect before the next edge.
    pix_ce = 1'b1;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_values("async");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ncyc = 0;
    first_fs = 0;
    fc_at_fs = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1'b1);
      if (s_frame_start && first_fs == 0) begin
        first_fs = ncyc;
        fc_at_fs = 32'(s_frame_count);
      end
    end
    check("post_reset_first_fs_clks", first_fs, 32'd42);
    check("post_reset_fc_at_fs", fc_at_fs, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
